// File: rtl/kbonacci_gen.sv
// kbonacci_gen: programmable k-bonacci term generator.
// Streams n terms on valid/ready; wrap or saturate on overflow.
module kbonacci_gen #(
    parameter int width    = 32,
    parameter int order    = 3,
    parameter int cnt_w    = 16,
    parameter bit saturate = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [2:0]       seed_idx,
    input  logic [width-1:0] seed_data,
    input  logic             start,
    input  logic [cnt_w-1:0] n_terms,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [cnt_w-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [width-1:0] s [order];
    logic [width-1:0] w [order];
    logic [cnt_w-1:0] remaining;
    logic [width+2:0] sum;
    logic             sum_ovf;
    logic [width-1:0] nxt;
    logic             hs;
    logic             last;
    logic             load;

    assign hs        = (state == RUN) && out_ready && !abort;
    assign last      = (remaining == cnt_w'(1));
    assign load      = (state == IDLE) && start && (n_terms != '0);
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign out_data  = w[0];

    // Sum of the whole window, 3 guard bits cover up to 8 terms
    always_comb begin
        sum = '0;
        for (int i = 0; i < order; i++) begin
            sum = sum + {3'b000, w[i]};
        end
    end

    assign sum_ovf = |sum[width+2:width];
    assign nxt     = (saturate && sum_ovf) ? '1 : sum[width-1:0];

    // Seed bank: writable only while idle, out-of-range indices never match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < order; i++) begin
                s[i] <= (i == 0) ? '0 : width'(1);
            end
        end else if (state == IDLE && seed_we) begin
            for (int i = 0; i < order; i++) begin
                if (seed_idx == 3'(i)) begin
                    s[i] <= seed_data;
                end
            end
        end
    end

    // Window: reload from the seed bank on start, shift on each handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < order; i++) begin
                w[i] <= (i == 0) ? '0 : width'(1);
            end
        end else if (load) begin
            for (int i = 0; i < order; i++) begin
                w[i] <= s[i];
            end
        end else if (hs) begin
            for (int i = 0; i < order - 1; i++) begin
                w[i] <= w[i+1];
            end
            w[order-1] <= nxt;
        end
    end

    // Control: state, remaining count, term index and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            out_idx   <= '0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ovf <= 1'b0;
                        if (n_terms != '0) begin
                            remaining <= n_terms;
                            out_idx   <= '0;
                            state     <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (out_ready) begin
                        remaining <= remaining - cnt_w'(1);
                        if (sum_ovf) begin
                            ovf <= 1'b1;
                        end
                        if (last) begin
                            state <= DONE;
                        end else begin
                            out_idx <= out_idx + cnt_w'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbonacci_gen.sv
// tb_kbonacci_gen: three generator configurations driven in lockstep,
// each checked against a list-based recurrence model.
module tb_kbonacci_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_we = 1'b0;
    logic [2:0]  seed_idx = '0;
    logic [15:0] sd = '0;
    logic        start = 1'b0;
    logic [15:0] n_terms = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic [2:0]  v, b, dn, ov;
    logic [7:0]  d0, d1;
    logic [15:0] d2;
    logic [15:0] ix0, ix1, ix2;

    int n_chk = 0;
    int n_err = 0;

    int ordv[3] = '{3, 3, 2};
    int widv[3] = '{8, 8, 16};
    int satv[3] = '{0, 1, 0};

    longint sb[3][8];
    longint e[3][80];
    bit     oc[3][80];

    always #5 clk = ~clk;

    kbonacci_gen #(.width(8), .order(3), .saturate(1'b0)) u0 (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_data(sd[7:0]), .start(start), .n_terms(n_terms),
        .abort(abort), .out_valid(v[0]), .out_ready(out_ready),
        .out_data(d0), .out_idx(ix0), .busy(b[0]), .done(dn[0]),
        .ovf(ov[0])
    );

    kbonacci_gen #(.width(8), .order(3), .saturate(1'b1)) u1 (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_data(sd[7:0]), .start(start), .n_terms(n_terms),
        .abort(abort), .out_valid(v[1]), .out_ready(out_ready),
        .out_data(d1), .out_idx(ix1), .busy(b[1]), .done(dn[1]),
        .ovf(ov[1])
    );

    kbonacci_gen #(.width(16), .order(2), .saturate(1'b0)) u2 (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_data(sd), .start(start), .n_terms(n_terms),
        .abort(abort), .out_valid(v[2]), .out_ready(out_ready),
        .out_data(d2), .out_idx(ix2), .busy(b[2]), .done(dn[2]),
        .ovf(ov[2])
    );

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint dat(input int d);
        case (d)
            0:       return longint'(d0);
            1:       return longint'(d1);
            default: return longint'(d2);
        endcase
    endfunction

    function automatic longint idx(input int d);
        case (d)
            0:       return longint'(ix0);
            1:       return longint'(ix1);
            default: return longint'(ix2);
        endcase
    endfunction

    function automatic longint mask(input int d);
        return (longint'(1) << widv[d]) - 1;
    endfunction

    task automatic seeds_default();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                sb[d][i] = (i == 0) ? 0 : 1;
            end
        end
    endtask

    // Term list: seeds, then each term is the sum of the previous ORDER
    task automatic build(input int n);
        longint sm, lim;
        for (int d = 0; d < 3; d++) begin
            lim = longint'(1) << widv[d];
            for (int k = 0; k < ordv[d]; k++) begin
                e[d][k]  = sb[d][k];
                oc[d][k] = 1'b0;
            end
            for (int k = ordv[d]; k < n + ordv[d]; k++) begin
                sm = 0;
                for (int j = k - ordv[d]; j < k; j++) sm += e[d][j];
                oc[d][k] = (sm >= lim);
                if (sm >= lim) e[d][k] = (satv[d] != 0) ? lim - 1 : sm % lim;
                else e[d][k] = sm;
            end
        end
    endtask

    // Sticky flag after h accepted terms
    function automatic longint ovexp(input int d, input int h);
        bit r = 1'b0;
        for (int j = ordv[d]; j < ordv[d] + h; j++) r |= oc[d][j];
        return longint'(r);
    endfunction

    task automatic wr(input int i, input logic [15:0] x);
        @(negedge clk);
        seed_we  = 1'b1;
        seed_idx = 3'(i);
        sd       = x;
        @(negedge clk);
        seed_we = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (i < ordv[d]) sb[d][i] = longint'(x) & mask(d);
        end
    endtask

    // mode 0: ready high, 1: toggling 1,0, 2: random
    task automatic run(input int n, input int mode, input int ab,
                       input bit junk, input bit ws);
        int k = 0;
        int cyc = 0;
        bit rdy;
        bit gone = 1'b0;
        logic [15:0] wd = '0;
        build(n);
        @(negedge clk);
        start   = 1'b1;
        n_terms = 16'(n);
        if (ws) begin
            wd       = 16'($urandom);
            seed_we  = 1'b1;
            seed_idx = 3'd0;
            sd       = wd;
        end
        @(negedge clk);
        start   = 1'b0;
        seed_we = 1'b0;
        if (ws) begin
            for (int d = 0; d < 3; d++) sb[d][0] = longint'(wd) & mask(d);
        end
        if (n == 0) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("z_valid%0d", d), longint'(v[d]), 0);
                check($sformatf("z_done%0d", d), longint'(dn[d]), 1);
                check($sformatf("z_ovf%0d", d), longint'(ov[d]), 0);
            end
            @(negedge clk);
            check("z_done_end", longint'(dn[0]), 0);
            return;
        end
        while (k < n && cyc < 400) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("valid%0d", d), longint'(v[d]), 1);
                check($sformatf("busy%0d", d), longint'(b[d]), 1);
                check($sformatf("done%0d", d), longint'(dn[d]), 0);
                check($sformatf("idx%0d", d), idx(d), longint'(k));
                check($sformatf("data%0d_%0d", d, k), dat(d), e[d][k]);
                check($sformatf("ovf%0d", d), longint'(ov[d]), ovexp(d, k));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            abort     = (k == ab);
            if (junk) begin
                seed_we  = 1'b1;
                seed_idx = 3'($urandom_range(0, 7));
                sd       = 16'($urandom);
                start    = 1'b1;
                n_terms  = 16'($urandom_range(0, 9));
            end
            @(negedge clk);
            out_ready = 1'b0;
            seed_we   = 1'b0;
            start     = 1'b0;
            cyc++;
            if (abort) begin
                abort = 1'b0;
                gone  = 1'b1;
                break;
            end
            if (rdy) k++;
        end
        if (gone) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("ab_valid%0d", d), longint'(v[d]), 0);
                check($sformatf("ab_busy%0d", d), longint'(b[d]), 0);
                check($sformatf("ab_done%0d", d), longint'(dn[d]), 0);
                check($sformatf("ab_ovf%0d", d), longint'(ov[d]), ovexp(d, k));
            end
            @(negedge clk);
            check("ab_done_late", longint'(dn[0]), 0);
            return;
        end
        if (k < n) begin
            check("timeout", longint'(k), longint'(n));
            return;
        end
        if (mode == 1) check("toggle_cycles", longint'(cyc), longint'(2 * n - 1));
        for (int d = 0; d < 3; d++) begin
            check($sformatf("end_done%0d", d), longint'(dn[d]), 1);
            check($sformatf("end_valid%0d", d), longint'(v[d]), 0);
            check($sformatf("end_ovf%0d", d), longint'(ov[d]), ovexp(d, n));
        end
        @(negedge clk);
        check("end_done_clear", longint'(dn[0]), 0);
        check("end_busy_clear", longint'(b[0]), 0);
    endtask

    initial begin
        int n;
        int ab;
        seeds_default();
        #1 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid%0d", d), longint'(v[d]), 0);
            check($sformatf("rst_busy%0d", d), longint'(b[d]), 0);
            check($sformatf("rst_done%0d", d), longint'(dn[d]), 0);
            check($sformatf("rst_ovf%0d", d), longint'(ov[d]), 0);
            check($sformatf("rst_idx%0d", d), idx(d), 0);
            check($sformatf("rst_data%0d", d), dat(d), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        run(8, 0, -1, 1'b0, 1'b0);
        run(13, 0, -1, 1'b0, 1'b0);
        run(10, 1, -1, 1'b0, 1'b0);

        wr(0, 16'd5);
        wr(1, 16'd3);
        wr(2, 16'd2);
        run(4, 0, -1, 1'b1, 1'b0);
        run(4, 2, -1, 1'b0, 1'b0);

        run(0, 0, -1, 1'b0, 1'b0);
        run(8, 0, 3, 1'b0, 1'b0);
        run(5, 0, -1, 1'b0, 1'b1);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) begin
                wr(int'($urandom_range(0, 7)), 16'($urandom));
            end
            n  = int'($urandom_range(0, 25));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            run(n, int'($urandom_range(0, 2)), ab,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        wr(0, 16'd9);
        wr(1, 16'd7);
        @(negedge clk);
        start   = 1'b1;
        n_terms = 16'd10;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("mr_valid%0d", d), longint'(v[d]), 0);
            check($sformatf("mr_busy%0d", d), longint'(b[d]), 0);
            check($sformatf("mr_ovf%0d", d), longint'(ov[d]), 0);
            check($sformatf("mr_idx%0d", d), idx(d), 0);
            check($sformatf("mr_data%0d", d), dat(d), 0);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seeds_default();
        run(4, 0, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
